// File: rtl/key_sampler_pkg.sv
// Shared types and constants for the key_bit_sampler input conditioner.
package key_sampler_pkg;

  // Debounce FSM states; encodings are visible on the sampler_state debug port.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b11,
    RELEASE_WAIT = 2'b10
  } sampler_state_t;

  // Width of the wrapping press counter.
  localparam int unsigned PRESS_COUNT_W = 6;

endpackage

// File: rtl/key_bit_sampler_sync2.sv
// sync2: 1-bit two-flop synchroniser with synchronous reset to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to resolve metastability of the asynchronous input.
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_bit_sampler.sv
// key_bit_sampler: synchronises key1/switch0, debounces key1 and emits one
// bit_valid strobe per accepted press carrying the synchronised switch value.
// Also keeps a wrapping press counter and a shift history of accepted bits.
// Optional macro SAMPLER_KEY_ACTIVE_LOW_EN: key1=0 means pressed.
module key_bit_sampler
  import key_sampler_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HISTORY_BITS    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key1,
  input  logic                     switch0,
  output logic                     bit_valid,
  output logic                     bit_value,
  output logic [PRESS_COUNT_W-1:0] press_count,
  output logic [HISTORY_BITS-1:0]  history,
  output logic [1:0]               sampler_state
);

  localparam int unsigned          CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic key_sync;
  logic key_s;
  logic sw_s;

`ifdef SAMPLER_KEY_ACTIVE_LOW_EN
  // Key synchroniser resets to the released level (1) so that the inverted
  // key_s does not look like a press for the two cycles after reset.
  sync2 #(.RST_VAL(1'b1)) u_key_sync (
    .clock (clock),
    .reset (reset),
    .d     (key1),
    .q     (key_sync)
  );
  assign key_s = ~key_sync;
`else
  sync2 #(.RST_VAL(1'b0)) u_key_sync (
    .clock (clock),
    .reset (reset),
    .d     (key1),
    .q     (key_sync)
  );
  assign key_s = key_sync;
`endif

  sync2 #(.RST_VAL(1'b0)) u_sw_sync (
    .clock (clock),
    .reset (reset),
    .d     (switch0),
    .q     (sw_s)
  );

  sampler_state_t           state,     state_d;
  logic [CNT_W-1:0]         cnt,       cnt_d;
  logic                     valid_d;
  logic                     value_d;
  logic [PRESS_COUNT_W-1:0] count_d;
  logic [HISTORY_BITS-1:0]  history_d;
  logic [HISTORY_BITS-1:0]  history_shifted;

  // Shift-in of the new bit; a 1-bit history simply takes the new bit.
  if (HISTORY_BITS == 1) begin : g_hist_one
    assign history_shifted = sw_s;
  end else begin : g_hist_many
    assign history_shifted = {history[HISTORY_BITS-2:0], sw_s};
  end

  assign sampler_state = state;

  // Debounce next-state logic plus strobe/counter/history updates on acceptance.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    valid_d   = 1'b0;
    value_d   = bit_value;
    count_d   = press_count;
    history_d = history;
    case (state)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CNT_MAX) begin
          state_d   = PRESSED;
          valid_d   = 1'b1;
          value_d   = sw_s;
          count_d   = press_count + PRESS_COUNT_W'(1);
          history_d = history_shifted;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = PRESSED;
        end else if (cnt == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_valid   <= 1'b0;
      bit_value   <= 1'b0;
      press_count <= '0;
      history     <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      bit_valid   <= valid_d;
      bit_value   <= value_d;
      press_count <= count_d;
      history     <= history_d;
    end
  end

endmodule
